// File: rtl/ram_steuerung_pkg.sv
// Shared types and widths for the ram_steuerung SRAM controller.
package ram_steuerung_pkg;

  localparam int unsigned HALB_W = 16;
  localparam int unsigned WORT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEAT0  = 2'd1,
    BEAT1  = 2'd2,
    FERTIG = 2'd3
  } zustand_t;

endpackage

// File: rtl/ram_steuerung_if.sv
// Cache-side request/response and SRAM pin bundle of the ram_steuerung controller.
interface ram_steuerung_if
  import ram_steuerung_pkg::*;
#(
  parameter int unsigned ADDR_W = 18
) ();

  logic              Lesen;
  logic              Schreiben;
  logic [WORT_W-1:0] Adresse;
  logic [WORT_W-1:0] SchreibDaten;
  logic [WORT_W-1:0] LesDaten;
  logic              DatenGelesen;
  logic              DatenGeschrieben;
  logic [ADDR_W-1:0] SramAdresse;
  logic [HALB_W-1:0] SramDatenIn;
  logic [HALB_W-1:0] SramDatenOut;
  logic              SramDatenOE;
  logic              SramCE_n;
  logic              SramOE_n;
  logic              SramWE_n;

  // slave: the controller; master: cache plus SRAM environment
  modport slave (
    input  Lesen, Schreiben, Adresse, SchreibDaten, SramDatenIn,
    output LesDaten, DatenGelesen, DatenGeschrieben,
           SramAdresse, SramDatenOut, SramDatenOE, SramCE_n, SramOE_n, SramWE_n
  );

  modport master (
    output Lesen, Schreiben, Adresse, SchreibDaten, SramDatenIn,
    input  LesDaten, DatenGelesen, DatenGeschrieben,
           SramAdresse, SramDatenOut, SramDatenOE, SramCE_n, SramOE_n, SramWE_n
  );

endinterface

// File: rtl/sram_halbwort.sv
// One SRAM halfword beat: WAIT_CYCLES+1 cycles of registered strobes, address and data.
module sram_halbwort
  import ram_steuerung_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              schreib,
  input  logic [ADDR_W-1:0] beat_adresse,
  input  logic [HALB_W-1:0] beat_daten,
  output logic              letzter_c,
  output logic [ADDR_W-1:0] adresse,
  output logic [HALB_W-1:0] daten,
  output logic              daten_oe,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LETZT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] HALTE = CNT_W'(WAIT_CYCLES - 1);

  logic             aktiv;
  logic [CNT_W-1:0] zaehler;

  assign letzter_c = aktiv && (zaehler == LETZT);

  // a new start on the last cycle chains the next beat without a gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aktiv    <= 1'b0;
      zaehler  <= '0;
      adresse  <= '0;
      daten    <= '0;
      daten_oe <= 1'b0;
      ce_n     <= 1'b1;
      oe_n     <= 1'b1;
      we_n     <= 1'b1;
    end else if (start) begin
      aktiv    <= 1'b1;
      zaehler  <= '0;
      adresse  <= beat_adresse;
      if (schreib) daten <= beat_daten;
      daten_oe <= schreib;
      ce_n     <= 1'b0;
      oe_n     <= schreib;
      we_n     <= !schreib;
    end else if (aktiv) begin
      zaehler <= zaehler + CNT_W'(1);
      if (zaehler == HALTE) we_n <= 1'b1;
      if (letzter_c) begin
        aktiv    <= 1'b0;
        zaehler  <= '0;
        daten_oe <= 1'b0;
        ce_n     <= 1'b1;
        oe_n     <= 1'b1;
        we_n     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_steuerung.sv
// 32-bit word RAM controller: each request becomes two 16-bit SRAM beats.
// Optional one-word read buffer compiled in with RAM_LESEPUFFER_EN.
module ram_steuerung
  import ram_steuerung_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            Clock,
  input logic            Reset,
  ram_steuerung_if.slave bus
);

  localparam int unsigned WADR_W = ADDR_W - 1;

  zustand_t          zustand, zustand_nxt;
  logic              op_schreib;
  logic [WADR_W-1:0] adr_q;
  logic [WORT_W-1:0] daten_q;
  logic [HALB_W-1:0] lo_q;

  logic              start_c, schreib_c, annahme_c, letzter_c;
  logic              gelesen_c, geschrieben_c;
  logic [ADDR_W-1:0] beat_adr_c;
  logic [HALB_W-1:0] beat_daten_c;
  logic              treffer_c;
  logic [WORT_W-1:0] treffer_daten_c;
  logic              unused_adresse;

  assign unused_adresse = ^bus.Adresse;

`ifdef RAM_LESEPUFFER_EN
  logic              puffer_gueltig;
  logic [WORT_W-1:0] puffer_tag, puffer_daten, tag_q;

  assign treffer_c       = puffer_gueltig && (puffer_tag == bus.Adresse);
  assign treffer_daten_c = puffer_daten;

  // completed SRAM reads fill the buffer, accepted writes invalidate it
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      puffer_gueltig <= 1'b0;
      puffer_tag     <= '0;
      puffer_daten   <= '0;
      tag_q          <= '0;
    end else begin
      if (annahme_c) tag_q <= bus.Adresse;
      if (annahme_c && bus.Schreiben) begin
        puffer_gueltig <= 1'b0;
      end else if (zustand == BEAT1 && letzter_c && !op_schreib) begin
        puffer_gueltig <= 1'b1;
        puffer_tag     <= tag_q;
        puffer_daten   <= {bus.SramDatenIn, lo_q};
      end
    end
  end
`else
  assign treffer_c       = 1'b0;
  assign treffer_daten_c = '0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) zustand <= IDLE;
    else        zustand <= zustand_nxt;
  end

  // next state and beat launch; IDLE feeds live inputs, later beats use the latches
  always_comb begin
    zustand_nxt   = zustand;
    start_c       = 1'b0;
    annahme_c     = 1'b0;
    schreib_c     = op_schreib;
    beat_adr_c    = {adr_q, 1'b1};
    beat_daten_c  = daten_q[WORT_W-1:HALB_W];
    gelesen_c     = 1'b0;
    geschrieben_c = 1'b0;
    case (zustand)
      IDLE: begin
        beat_adr_c   = {bus.Adresse[WADR_W-1:0], 1'b0};
        beat_daten_c = bus.SchreibDaten[HALB_W-1:0];
        if (bus.Schreiben) begin
          annahme_c   = 1'b1;
          start_c     = 1'b1;
          schreib_c   = 1'b1;
          zustand_nxt = BEAT0;
        end else if (bus.Lesen) begin
          annahme_c = 1'b1;
          schreib_c = 1'b0;
          if (treffer_c) begin
            gelesen_c   = 1'b1;
            zustand_nxt = FERTIG;
          end else begin
            start_c     = 1'b1;
            zustand_nxt = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (letzter_c) begin
          start_c     = 1'b1;
          zustand_nxt = BEAT1;
        end
      end
      BEAT1: begin
        if (letzter_c) begin
          gelesen_c     = !op_schreib;
          geschrieben_c = op_schreib;
          zustand_nxt   = FERTIG;
        end
      end
      FERTIG:  zustand_nxt = IDLE;
      default: zustand_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_schreib           <= 1'b0;
      adr_q                <= '0;
      daten_q              <= '0;
      lo_q                 <= '0;
      bus.LesDaten         <= '0;
      bus.DatenGelesen     <= 1'b0;
      bus.DatenGeschrieben <= 1'b0;
    end else begin
      bus.DatenGelesen     <= gelesen_c;
      bus.DatenGeschrieben <= geschrieben_c;
      if (annahme_c) begin
        op_schreib <= bus.Schreiben;
        adr_q      <= bus.Adresse[WADR_W-1:0];
        daten_q    <= bus.SchreibDaten;
      end
      if (zustand == BEAT0 && letzter_c) lo_q <= bus.SramDatenIn;
      if (gelesen_c)
        bus.LesDaten <= (zustand == IDLE) ? treffer_daten_c : {bus.SramDatenIn, lo_q};
    end
  end

  sram_halbwort #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_beat (
    .clk          (Clock),
    .rst_n        (Reset),
    .start        (start_c),
    .schreib      (schreib_c),
    .beat_adresse (beat_adr_c),
    .beat_daten   (beat_daten_c),
    .letzter_c    (letzter_c),
    .adresse      (bus.SramAdresse),
    .daten        (bus.SramDatenOut),
    .daten_oe     (bus.SramDatenOE),
    .ce_n         (bus.SramCE_n),
    .oe_n         (bus.SramOE_n),
    .we_n         (bus.SramWE_n)
  );

endmodule

// File: tb/tb_ram_steuerung.sv
// Self-checking bench for ram_steuerung with an asynchronous SRAM model and word-level reference.
module tb_ram_steuerung;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned W      = 2;
  localparam int          BEAT   = W + 1;
  localparam int          LAT    = 2 * BEAT + 1;
  localparam logic [31:0] MASKE  = (32'd1 << (ADDR_W - 1)) - 32'd1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ram_steuerung_if #(.ADDR_W(ADDR_W)) bus ();

  ram_steuerung #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural state: SRAM halfwords, reference words, read-buffer model
  logic [15:0] sram    [int];
  logic [31:0] ref_mem [int];
`ifdef RAM_LESEPUFFER_EN
  bit          m_gueltig;
  logic [31:0] m_tag;
`endif

  function automatic logic [15:0] sram_lesen(int a);
    if (sram.exists(a)) return sram[a];
    return 16'h0000;
  endfunction

  function automatic logic [31:0] ref_lesen(logic [31:0] adr);
    int k = int'(adr & MASKE);
    if (ref_mem.exists(k)) return ref_mem[k];
    return 32'h0;
  endfunction

  function automatic void ref_schreiben(logic [31:0] adr, logic [31:0] d);
    ref_mem[int'(adr & MASKE)] = d;
  endfunction

  function automatic void modell_reset();
`ifdef RAM_LESEPUFFER_EN
    m_gueltig = 1'b0;
`endif
  endfunction

  // expected cycles from acceptance to done pulse
  function automatic int modell_lat(bit s, logic [31:0] adr);
    if (s) begin
`ifdef RAM_LESEPUFFER_EN
      m_gueltig = 1'b0;
`endif
      return LAT;
    end
`ifdef RAM_LESEPUFFER_EN
    if (m_gueltig && m_tag == adr) return 1;
    m_gueltig = 1'b1;
    m_tag     = adr;
`endif
    return LAT;
  endfunction

  // asynchronous SRAM: combinational read when selected, level write while WE_n low
  always @(negedge clk) begin
    if (!bus.SramCE_n && !bus.SramWE_n && bus.SramDatenOE)
      sram[int'(bus.SramAdresse)] = bus.SramDatenOut;
    bus.SramDatenIn = (!bus.SramCE_n && !bus.SramOE_n) ? sram_lesen(int'(bus.SramAdresse)) : 16'hDEAD;
  end

  int          t_lat, t_gel, t_ges, t_ce, t_oe, t_we, t_doe;
  logic [15:0] t_wepat;
  logic [ADDR_W-1:0] t_a0, t_a1;
  logic [31:0] t_rdata;

  // one request held until its pulse; called and returns at a negedge with the DUT idle
  task automatic transakt(input bit s, input bit l, input logic [31:0] adr, input logic [31:0] wd,
                          input bit drop, input bit wackeln);
    t_lat = -1; t_gel = 0; t_ges = 0; t_ce = 0; t_oe = 0; t_we = 0; t_doe = 0;
    t_wepat = '1; t_a0 = '0; t_a1 = '0; t_rdata = '0;
    bus.Schreiben = s; bus.Lesen = l; bus.Adresse = adr; bus.SchreibDaten = wd;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1 && drop) begin bus.Schreiben = 1'b0; bus.Lesen = 1'b0; end
      if (k == 1 && wackeln) begin bus.Adresse = $urandom; bus.SchreibDaten = $urandom; end
      if (!bus.SramCE_n) t_ce++;
      if (!bus.SramCE_n && !bus.SramOE_n) t_oe++;
      if (!bus.SramWE_n) t_we++;
      if (bus.SramDatenOE) t_doe++;
      if (k <= 16) t_wepat[k-1] = bus.SramWE_n;
      if (k == 1) t_a0 = bus.SramAdresse;
      if (k == BEAT + 1) t_a1 = bus.SramAdresse;
      if (bus.DatenGelesen) begin
        t_gel++;
        if (t_lat < 0) begin t_lat = k; t_rdata = bus.LesDaten; end
      end
      if (bus.DatenGeschrieben) begin
        t_ges++;
        if (t_lat < 0) t_lat = k;
      end
      if (t_lat > 0 && k == t_lat) begin bus.Lesen = 1'b0; bus.Schreiben = 1'b0; end
      if (t_lat > 0 && k == t_lat + 1) break;
    end
    bus.Lesen = 1'b0; bus.Schreiben = 1'b0;
  endtask

  function automatic logic [15:0] we_muster();
    logic [15:0] m = '1;
    for (int c = 0; c < 2 * BEAT; c++) m[c] = ((c % BEAT) == W);
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.Lesen = 1'b0; bus.Schreiben = 1'b0; bus.Adresse = '0; bus.SchreibDaten = '0;
    modell_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.SramCE_n !== 1'b1 || bus.SramOE_n !== 1'b1 || bus.SramWE_n !== 1'b1) begin
      errors++; $display("FAIL reset_strobes: got ce/oe/we=%b%b%b want 111", bus.SramCE_n, bus.SramOE_n, bus.SramWE_n); end
    checks++; if (bus.SramDatenOE !== 1'b0 || bus.SramAdresse !== '0 || bus.SramDatenOut !== '0) begin
      errors++; $display("FAIL reset_bus: got oe=%b adr=%h out=%h want 0", bus.SramDatenOE, bus.SramAdresse, bus.SramDatenOut); end
    checks++; if (bus.LesDaten !== 32'h0 || bus.DatenGelesen !== 1'b0 || bus.DatenGeschrieben !== 1'b0) begin
      errors++; $display("FAIL reset_outs: got les=%h gel=%b ges=%b want 0", bus.LesDaten, bus.DatenGelesen, bus.DatenGeschrieben); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.SramCE_n !== 1'b1 || bus.DatenGelesen !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ce=%b gel=%b want 1 0", bus.SramCE_n, bus.DatenGelesen); end
  endtask

  task automatic test_read();
    sram[6] = 16'h0008; sram[7] = 16'h0000; ref_schreiben(32'd3, 32'h0000_0008);
    checks++; if (modell_lat(1'b0, 32'd3) !== LAT) begin errors++; $display("FAIL read_model_lat: want %0d", LAT); end
    transakt(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);
    checks++; if (t_a0 !== ADDR_W'(6) || t_a1 !== ADDR_W'(7)) begin
      errors++; $display("FAIL read_adr: got %0d/%0d want 6/7", t_a0, t_a1); end
    checks++; if (t_oe !== 2 * BEAT) begin errors++; $display("FAIL read_oe_cycles: got %0d want %0d", t_oe, 2 * BEAT); end
    checks++; if (t_lat !== LAT) begin errors++; $display("FAIL read_lat: got %0d want %0d", t_lat, LAT); end
    checks++; if (t_rdata !== 32'h0000_0008) begin errors++; $display("FAIL read_data: got %h want 00000008", t_rdata); end
    checks++; if (t_gel !== 1 || t_ges !== 0) begin errors++; $display("FAIL read_pulses: got gel=%0d ges=%0d want 1 0", t_gel, t_ges); end
    checks++; if (bus.LesDaten !== 32'h0000_0008) begin errors++; $display("FAIL read_hold: got %h want 00000008", bus.LesDaten); end
  endtask

  task automatic test_write();
    void'(modell_lat(1'b1, 32'h40));
    transakt(1'b1, 1'b0, 32'h40, 32'h1234_ABCD, 1'b0, 1'b0);
    ref_schreiben(32'h40, 32'h1234_ABCD);
    checks++; if (sram_lesen(32'h80) !== 16'hABCD || sram_lesen(32'h81) !== 16'h1234) begin
      errors++; $display("FAIL write_mem: got %h/%h want abcd/1234", sram_lesen(32'h80), sram_lesen(32'h81)); end
    checks++; if (t_wepat !== we_muster()) begin errors++; $display("FAIL write_we_pattern: got %b want %b", t_wepat, we_muster()); end
    checks++; if (t_doe !== 2 * BEAT) begin errors++; $display("FAIL write_doe: got %0d want %0d", t_doe, 2 * BEAT); end
    checks++; if (t_lat !== LAT || t_ges !== 1 || t_gel !== 0) begin
      errors++; $display("FAIL write_pulse: got lat=%0d ges=%0d gel=%0d want %0d 1 0", t_lat, t_ges, t_gel, LAT); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d = $urandom;
    void'(modell_lat(1'b1, 32'd1));
    transakt(1'b1, 1'b1, 32'd1, d, 1'b0, 1'b0);
    ref_schreiben(32'd1, d);
    checks++; if (t_ges !== 1 || t_gel !== 0) begin errors++; $display("FAIL simul_pulses: got ges=%0d gel=%0d want 1 0", t_ges, t_gel); end
    checks++; if (t_we !== 2 * W || t_doe !== 2 * BEAT) begin
      errors++; $display("FAIL simul_write: got we=%0d doe=%0d want %0d %0d", t_we, t_doe, 2 * W, 2 * BEAT); end
    checks++; if ({sram_lesen(3), sram_lesen(2)} !== d) begin
      errors++; $display("FAIL simul_mem: got %h want %h", {sram_lesen(3), sram_lesen(2)}, d); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int soll;
    bit fertig = 1'b0;
    bus.Lesen = 1'b1; bus.Adresse = 32'd0;
    soll = modell_lat(1'b0, 32'd0);
    for (int cyc = 1; cyc <= 80 && !fertig; cyc++) begin
      @(negedge clk);
      if (bus.DatenGelesen) begin
        checks++; if (cyc !== soll) begin errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d want %0d", n, cyc, soll); end
        checks++; if (bus.LesDaten !== ref_lesen(32'(n))) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, bus.LesDaten, ref_lesen(32'(n))); end
        n++;
        if (n == 4) begin bus.Lesen = 1'b0; fertig = 1'b1; end
        else begin
          bus.Adresse = 32'(n);
          soll = cyc + 1 + modell_lat(1'b0, 32'(n));
        end
      end
    end
    bus.Lesen = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d pulses want 4", n); end
    @(negedge clk);
    void'(modell_lat(1'b0, 32'h4000_0001));
    transakt(1'b0, 1'b1, 32'h4000_0001, 32'h0, 1'b0, 1'b0);
    checks++; if (t_a0 !== ADDR_W'(2) || t_a1 !== ADDR_W'(3)) begin
      errors++; $display("FAIL alias_adr: got %0d/%0d want 2/3", t_a0, t_a1); end
    checks++; if (t_rdata !== ref_lesen(32'd1)) begin errors++; $display("FAIL alias_data: got %h want %h", t_rdata, ref_lesen(32'd1)); end
  endtask

  task automatic test_reset_mid_write();
    int p = 0;
    int c = 0;
    bus.Schreiben = 1'b1; bus.Adresse = 32'h1F000; bus.SchreibDaten = 32'hCAFE_F00D;
    @(posedge clk);
    repeat (BEAT + 1) @(negedge clk);
    rst_n = 1'b0; bus.Schreiben = 1'b0;
    #1;
    checks++; if (bus.SramCE_n !== 1'b1 || bus.SramWE_n !== 1'b1 || bus.SramOE_n !== 1'b1 || bus.SramDatenOE !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got ce/we/oe/doe=%b%b%b%b want 1110", bus.SramCE_n, bus.SramWE_n, bus.SramOE_n, bus.SramDatenOE); end
    modell_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.DatenGeschrieben || bus.DatenGelesen) p++;
      if (!bus.SramCE_n) c++;
    end
    checks++; if (p !== 0 || c !== 0) begin errors++; $display("FAIL rst_mid_quiet: got pulses=%0d ce=%0d want 0 0", p, c); end
  endtask

  task automatic test_lesepuffer();
    int l;
    l = modell_lat(1'b0, 32'd3);
    transakt(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);
    checks++; if (t_lat !== l) begin errors++; $display("FAIL buf_first_lat: got %0d want %0d", t_lat, l); end
    l = modell_lat(1'b0, 32'd3);
    transakt(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);
    checks++; if (t_lat !== l || t_ce !== ((l == 1) ? 0 : 2 * BEAT)) begin
      errors++; $display("FAIL buf_second: got lat=%0d ce=%0d want lat %0d", t_lat, t_ce, l); end
    checks++; if (t_rdata !== ref_lesen(32'd3)) begin errors++; $display("FAIL buf_second_data: got %h want %h", t_rdata, ref_lesen(32'd3)); end
    void'(modell_lat(1'b1, 32'd3));
    transakt(1'b1, 1'b0, 32'd3, 32'h5A5A_0F0F, 1'b0, 1'b0);
    ref_schreiben(32'd3, 32'h5A5A_0F0F);
    l = modell_lat(1'b0, 32'd3);
    transakt(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0);
    checks++; if (t_lat !== LAT || l !== LAT || t_ce !== 2 * BEAT) begin
      errors++; $display("FAIL buf_after_write: got lat=%0d ce=%0d want %0d %0d", t_lat, t_ce, LAT, 2 * BEAT); end
    checks++; if (t_rdata !== 32'h5A5A_0F0F) begin errors++; $display("FAIL buf_after_write_data: got %h want 5a5a0f0f", t_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit s = ($urandom_range(0, 2) == 0);
      bit l = !s || ($urandom_range(0, 1) == 1);
      logic [31:0] adr = 32'($urandom_range(0, 7));
      logic [31:0] wd  = $urandom;
      logic [31:0] erw;
      int el;
      if ($urandom_range(0, 3) == 0) adr = adr | 32'h4000_0000;
      el  = modell_lat(s, adr);
      erw = ref_lesen(adr);
      transakt(s, l, adr, wd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      if (s) ref_schreiben(adr, wd);
      checks++; if (t_lat !== el) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, t_lat, el); end
      checks++; if (t_ges !== int'(s) || t_gel !== int'(!s)) begin
        errors++; $display("FAIL rnd_pulses[%0d]: got ges=%0d gel=%0d want %0d %0d", i, t_ges, t_gel, s, !s); end
      checks++; if (t_ce !== ((el == 1) ? 0 : 2 * BEAT)) begin errors++; $display("FAIL rnd_ce[%0d]: got %0d", i, t_ce); end
      if (!s) begin
        checks++; if (t_rdata !== erw) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, t_rdata, erw); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int a = 0; a < 8; a++) begin
      logic [31:0] d = $urandom;
      sram[2 * a] = d[15:0]; sram[2 * a + 1] = d[31:16];
      ref_schreiben(32'(a), d);
    end
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_write();
    test_lesepuffer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
